// File: rtl/slug_seq_pkg.sv
// slug_seq_pkg: shared types and phase constants for the slug run controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package slug_seq_pkg;

    typedef enum logic [1:0] {
        S_RESET  = 2'd0,
        S_HALTED = 2'd1,
        S_RUN    = 2'd2,
        S_STEP   = 2'd3
    } seq_state_t;

    typedef logic [2:0] phase_t;

    // Instruction phases: fetch, update, read, write, then one boundary cycle.
    localparam phase_t PH_P = 3'd0;
    localparam phase_t PH_U = 3'd1;
    localparam phase_t PH_R = 3'd2;
    localparam phase_t PH_W = 3'd3;
    localparam phase_t PH_B = 3'd4;

    // Enable vector {wclk, rclk, uclk, pclk} for a given phase.
    // The boundary phase and any out-of-range phase drive no enable.
    function automatic logic [3:0] phase_onehot(input phase_t p);
        logic [3:0] en;
        en = 4'b0000;
        case (p)
            PH_P:    en = 4'b0001;
            PH_U:    en = 4'b0010;
            PH_R:    en = 4'b0100;
            PH_W:    en = 4'b1000;
            default: en = 4'b0000;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/slug_phase_seq.sv
// slug_phase_seq: single-clock run controller; one-hot phase enables, reset hold,
//   run/halt/step, PC breakpoint and retired-instruction counter for the slug core.
// Latency: every output registered; pclk_en rises the cycle after run/step is sampled.
// Backpressure: none; run is a level, step/halt are pulses, halt is latched until boundary.
// Ports: sysclk/rst (sync, active-high); run, step, halt, core_halt, pc, bp_en, bp_addr in;
//   core_rst_n, pclk_en/uclk_en/rclk_en/wclk_en, state, bp_hit, instr_count out.
// Build option SLUG_SEQ_PERF_EN: adds cycle_count, cycles spent in S_RUN or S_STEP.
module slug_phase_seq
    import slug_seq_pkg::*;
#(
    parameter int PC_W       = 8,
    parameter int CNT_W      = 32,
    parameter int RST_CYCLES = 4
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic             halt,
    input  logic             core_halt,
    input  logic [PC_W-1:0]  pc,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    output logic             core_rst_n,
    output logic             pclk_en,
    output logic             uclk_en,
    output logic             rclk_en,
    output logic             wclk_en,
    output seq_state_t       state,
`ifdef SLUG_SEQ_PERF_EN
    output logic [CNT_W-1:0] cycle_count,
`endif
    output logic             bp_hit,
    output logic [CNT_W-1:0] instr_count
);

    localparam int RC_W = $clog2(RST_CYCLES) + 1;

    phase_t          phase;
    logic [3:0]      en_q;
    logic            halt_pend;
    // Set on leaving HALTED so the resumed instruction is never trapped again.
    logic            bp_skip;
    logic [RC_W-1:0] rst_cnt;

    assign pclk_en = en_q[0];
    assign uclk_en = en_q[1];
    assign rclk_en = en_q[2];
    assign wclk_en = en_q[3];

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state       <= S_RESET;
            phase       <= PH_P;
            en_q        <= 4'b0000;
            core_rst_n  <= 1'b0;
            bp_hit      <= 1'b0;
            instr_count <= '0;
            halt_pend   <= 1'b0;
            bp_skip     <= 1'b0;
            rst_cnt     <= '0;
        end else begin
            case (state)
                S_RESET: begin
                    if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
                        state      <= S_HALTED;
                        core_rst_n <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt + RC_W'(1);
                    end
                end

                S_HALTED: begin
                    if (run || step) begin
                        // run wins over step; a same-cycle halt is discarded by the exit.
                        state     <= run ? S_RUN : S_STEP;
                        phase     <= PH_P;
                        en_q      <= phase_onehot(PH_P);
                        bp_hit    <= 1'b0;
                        halt_pend <= 1'b0;
                        bp_skip   <= 1'b1;
                    end else if (halt) begin
                        halt_pend <= 1'b1;
                    end
                end

                S_RUN, S_STEP: begin
                    if (halt) begin
                        halt_pend <= 1'b1;
                    end
                    if (phase == PH_W) begin
                        instr_count <= instr_count + CNT_W'(1);
                    end
                    if (phase != PH_B) begin
                        // Mid-instruction: always advance, run is only looked at on the boundary.
                        phase <= phase + 3'd1;
                        en_q  <= phase_onehot(phase + 3'd1);
                    end else begin
                        bp_skip <= 1'b0;
                        if (state == S_STEP || halt_pend || !run || core_halt) begin
                            state <= S_HALTED;
                        end else if (bp_en && !bp_skip && (pc == bp_addr)) begin
                            state  <= S_HALTED;
                            bp_hit <= 1'b1;
                        end else begin
                            phase <= PH_P;
                            en_q  <= phase_onehot(PH_P);
                        end
                    end
                end

                default: state <= S_RESET;
            endcase
        end
    end

`ifdef SLUG_SEQ_PERF_EN
    always_ff @(posedge sysclk) begin
        if (rst) begin
            cycle_count <= '0;
        end else if (state == S_RUN || state == S_STEP) begin
            cycle_count <= cycle_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: doc/slug_phase_seq.md
Name: slug_phase_seq

Overview:
- Single-clock run controller for the slug core.
- Replaces free-running four-phase PLL clocks with one-hot phase enables (pclk/uclk/rclk/wclk order) derived from sysclk.
- Adds reset hold, run/halt, single-step, PC breakpoint and an instruction counter, so a debug host or testbench can sequence the core deterministically.

Parameters:
- PC_W, 8: width of core program counter / breakpoint address.
- CNT_W, 32: width of retired-instruction counter.
- RST_CYCLES, 4: cycles core_rst_n held low after rst deasserts (≥1).

Ports:
- sysclk  in  1  single system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level: keep executing while high.
- step  in  1  pulse: execute exactly one instruction from HALTED.
- halt  in  1  pulse: stop at next instruction boundary.
- core_halt  in  1  core decoded a HALT instruction; sampled at boundary.
- pc  in  PC_W  core PC of next instruction; valid in boundary cycle.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  PC_W  breakpoint address.
- core_rst_n  out  1  reset to core, low = held in reset.
- pclk_en  out  1  fetch-phase enable.
- uclk_en  out  1  update-phase enable.
- rclk_en  out  1  read-phase enable.
- wclk_en  out  1  write-phase enable.
- state  out  2  current controller state (package enum).
- bp_hit  out  1  sticky: halted by breakpoint.
- instr_count  out  CNT_W  instructions retired.

Behaviour:
- All outputs registered.
- On rst (at the clock edge where sampled high):
  - state=S_RESET; phase=0; all *_en=0; core_rst_n=0; bp_hit=0; instr_count=0; halt_pend=0; reset counter=0.
  - Applies mid-instruction too: enables drop at that edge, no partial phase completes.
- S_RESET:
  - Counts RST_CYCLES cycles after rst low, then goes to S_HALTED.
  - core_rst_n=1 from the first S_HALTED cycle.
  - run/step ignored.
- S_HALTED:
  - All enables 0.
  - run=1 → S_RUN, phase 0. Otherwise step=1 → S_STEP, phase 0. run has priority over step.
  - Leaving clears bp_hit and halt_pend.
  - pclk_en is high the cycle after run/step is sampled.
  - The first instruction after leaving HALTED is never breakpoint-checked, so resume from a breakpoint works.
- Instruction = 5 cycles, phase 0..4:
  - Phases 0–3 assert pclk_en, uclk_en, rclk_en, wclk_en respectively, exactly one high.
  - Phase 4 is the boundary cycle: no enable high.
- instr_count increments (wraps) in each wclk_en cycle.
- halt pulse in any non-reset state sets halt_pend.
- Boundary (phase 4) decision in S_RUN, priority order:
  1. halt_pend | !run | core_halt → S_HALTED.
  2. bp_en && pc==bp_addr → S_HALTED, bp_hit=1.
  3. Otherwise phase 0 of the next instruction.
- Boundary in S_STEP: unconditionally → S_HALTED. bp_hit unaffected.
- Deasserting run mid-instruction: the instruction completes all four phases; never truncated.
- halt and step in the same HALTED cycle: step taken, halt_pend cleared by the exit.
- A halt arriving during that step still stops at its boundary, which is a no-op since step halts anyway.

Optional Feature:
- Macro SLUG_SEQ_PERF_EN.
- Defined: adds output cycle_count (CNT_W), counting every cycle spent in S_RUN or S_STEP. Reset to 0 by rst; wraps.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package slug_seq_pkg holds:
  - typedef enum logic[1:0] {S_RESET, S_HALTED, S_RUN, S_STEP} seq_state_t.
  - typedef logic[2:0] phase_t.
  - Constants PH_P=0, PH_U=1, PH_R=2, PH_W=3, PH_B=4.
- No sub-module. Single FSM plus counters; the breakpoint compare is one line.

Test Plan:
- rst 1 cycle, RST_CYCLES=4 → core_rst_n low 4 cycles, then 1; state=S_HALTED; all enables 0; instr_count=0.
- run held high 3 instructions → enable pattern p,u,r,w,idle repeats at period 5; instr_count=3 after the third wclk_en; never two enables high.
- step pulse from HALTED → exactly one p,u,r,w sequence; state returns to S_HALTED at cycle 6; instr_count +1.
- run=1, bp_en=1, bp_addr=0x12:
  - pc=0x12 at the 2nd boundary → halt after 2 instructions, bp_hit=1.
  - Re-assert run with pc still 0x12 → executes without re-trapping; bp_hit cleared.
- halt pulse during rclk_en of instruction 5 → wclk_en still issued; state=S_HALTED at the following boundary; instr_count=5.
- rst asserted in a uclk_en cycle → next cycle all enables 0, instr_count=0, state=S_RESET; core_halt=1 at a boundary in S_RUN → S_HALTED.
